// File: rtl/fp_pkg.sv
// Shared single-precision constants and helpers for the FP resource
// arbiters (subtractor today, adder/multiplier later).
package fp_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_ZERO  = 32'h00000000;
    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F800000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h40000000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h40400000;
    localparam logic [FP_W-1:0] FP_FIVE  = 32'h40A00000;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr+1 (mod NREQ) and
// returns the first requester as a one-hot grant plus encoded index.
module rr_arbiter
    import fp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        // ptr itself is visited last, so the previous winner has lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fp_sub_arbiter.sv
// Shares one pipelined fp_sub between NREQ requesters; a tag pipeline
// tracks each issued op so the result returns with its owner's ID.
module fp_sub_arbiter
    import fp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3,
    parameter int IDW     = clog2(NREQ)
) (
    input  logic                            clk,
    input  logic                            areset,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [FP_W*NREQ-1:0]            req_a,
    input  logic [FP_W*NREQ-1:0]            req_b,
    output logic                            rsp_valid,
    output logic [IDW-1:0]                  rsp_id,
    output logic [FP_W-1:0]                 rsp_q,
    output logic [FP_W-1:0]                 fp_a,
    output logic [FP_W-1:0]                 fp_b,
    output logic                            fp_en,
    output logic                            fp_areset,
    input  logic [FP_W-1:0]                 fp_q,
    output logic [clog2(LATENCY+1)-1:0]     inflight,
    output logic                            idle
);

    localparam int CW = clog2(LATENCY + 1);

    logic [NREQ-1:0]    req_v;
    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gidx;
    logic               accept;

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [IDW-1:0]     id_q [LATENCY];
    logic [IDW-1:0]     id_d [LATENCY];
    logic [CW-1:0]      cnt_q, cnt_d;

    assign req_v = areset ? '0 : req_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (req_v),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gidx),
        .valid_o (accept)
    );

    assign req_ready = gnt;
    assign fp_en     = ~areset;
    assign fp_areset = areset;

    always_comb begin
        fp_a = FP_ZERO;
        fp_b = FP_ZERO;
        if (accept) begin
            fp_a = req_a[FP_W*int'(gidx) +: FP_W];
            fp_b = req_b[FP_W*int'(gidx) +: FP_W];
        end
    end

    always_comb begin
        ptr_d    = accept ? gidx : ptr_q;
        vld_d    = '0;
        vld_d[0] = accept;
        id_d[0]  = gidx;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            id_d[k]  = id_q[k-1];
        end
    end

    // Reset is synchronous, so mask the last stage while it is asserted
    assign rsp_valid = vld_q[LATENCY-1] & ~areset;
    assign rsp_id    = areset ? '0 : id_q[LATENCY-1];
    assign rsp_q     = fp_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, rsp_valid})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign inflight = cnt_q;
    assign idle     = areset | ((cnt_q == '0) && (req_valid == '0));

    always_ff @(posedge clk) begin
        if (areset) begin
            ptr_q <= IDW'(NREQ - 1);
            vld_q <= '0;
            cnt_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < LATENCY; k++) begin
                id_q[k] <= id_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Directed bench for fp_sub_arbiter with a behavioural pipelined
// fp_sub model behind the fp_* ports.
module tb_fp_sub_arbiter;
    import fp_pkg::*;

    localparam int NREQ    = 4;
    localparam int LATENCY = 3;
    localparam int IDW     = 2;
    localparam int CW      = 2;

    logic                 clk;
    logic                 areset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_q;
    logic [31:0]          fp_a;
    logic [31:0]          fp_b;
    logic                 fp_en;
    logic                 fp_areset;
    logic [31:0]          fp_q;
    logic [CW-1:0]        inflight;
    logic                 idle;

    int tests = 0;
    int fails = 0;

    fp_sub_arbiter #(
        .NREQ    (NREQ),
        .LATENCY (LATENCY),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .fp_a      (fp_a),
        .fp_b      (fp_b),
        .fp_en     (fp_en),
        .fp_areset (fp_areset),
        .fp_q      (fp_q),
        .inflight  (inflight),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural subtractor: single -> double, subtract, back to single
    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return from_real(to_real(a) - to_real(b));
    endfunction

    logic [31:0] pipe [LATENCY];

    always @(posedge clk) begin
        if (fp_areset) begin
            for (int k = 0; k < LATENCY; k++) pipe[k] <= 32'h0;
        end else if (fp_en) begin
            pipe[0] <= fsub(fp_a, fp_b);
            for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign fp_q = pipe[LATENCY-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 areset = 1'b0;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    task automatic issue_one(input int id, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] q);
        set_op(id, a, b);
        req_valid = 4'(1 << id);
        @(negedge clk);
        chk("vec_ready", 32'(req_ready), 32'(1 << id));
        chk("vec_inflight0", 32'(inflight), 32'd0);
        @(posedge clk);
        #1 req_valid = '0;
        for (int k = 1; k < LATENCY; k++) begin
            @(negedge clk);
            chk("vec_early_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_rsp_id", 32'(rsp_id), 32'(id));
        chk("vec_rsp_q", rsp_q, q);
        chk("vec_inflight1", 32'(inflight), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("vec_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("vec_inflight_end", 32'(inflight), 32'd0);
        chk("vec_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic granted3;
        logic double0;
        logic prev0;

        vecs[0] = '{1, FP_FIVE,  FP_THREE, FP_TWO};
        vecs[1] = '{2, FP_ONE,   FP_THREE, 32'hC0000000};
        vecs[2] = '{0, FP_ZERO,  FP_ZERO,  FP_ZERO};
        vecs[3] = '{3, FP_THREE, FP_ONE,   FP_TWO};
        vecs[4] = '{0, FP_TWO,   FP_FIVE,  32'hC0400000};
        vecs[5] = '{1, FP_FIVE,  FP_ONE,   32'h40800000};

        req_a     = '0;
        req_b     = '0;
        areset    = 1'b1;
        req_valid = '1;

        // Outputs while reset is held, even with every requester valid
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_fp_en", 32'(fp_en), 32'd0);
        chk("rst_fp_areset", 32'(fp_areset), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_fp_a", fp_a, 32'd0);
        do_reset();
        @(negedge clk);
        chk("post_rst_inflight", 32'(inflight), 32'd0);
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_fp_en", 32'(fp_en), 32'd1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            issue_one(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].q);
        end

        // All four valid back-to-back: grants rotate 0..3, results stream out
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, FP_THREE, FP_ONE);
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1 << (c % NREQ)));
            chk("rr_fp_a", fp_a, FP_THREE);
            if (c >= LATENCY) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((c - LATENCY) % NREQ));
                chk("rr_rsp_q", rsp_q, FP_TWO);
                chk("rr_inflight", 32'(inflight), 32'(LATENCY));
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        repeat (LATENCY + 1) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rr_drain_inflight", 32'(inflight), 32'd0);
        chk("rr_drain_idle", 32'(idle), 32'd1);

        // Fairness: req 0 hogs, req 3 joins later
        do_reset();
        set_op(0, FP_ONE, FP_ONE);
        set_op(3, FP_FIVE, FP_ONE);
        req_valid = 4'b0001;
        repeat (3) @(posedge clk);
        #1 req_valid = 4'b1001;
        granted3 = 1'b0;
        double0  = 1'b0;
        prev0    = 1'b1;
        for (int w = 0; w < NREQ && !granted3; w++) begin
            @(negedge clk);
            if (req_ready[3]) begin
                granted3 = 1'b1;
            end else if (req_ready[0] && prev0) begin
                double0 = 1'b1;
            end
            prev0 = req_ready[0];
            @(posedge clk);
            #1;
        end
        chk("fair_req3_granted", 32'(granted3), 32'd1);
        chk("fair_no_double0", 32'(double0), 32'd0);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("fair_back_to_0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (LATENCY + 1) @(posedge clk);
        #1;

        // Hold rule: req 1 waits one cycle with stable operands
        do_reset();
        set_op(0, FP_FIVE, FP_THREE);
        set_op(1, FP_ONE, FP_THREE);
        req_valid = 4'b0011;
        @(negedge clk);
        chk("hold_grant0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 4'b0010;
        @(negedge clk);
        chk("hold_grant1", 32'(req_ready), 32'd2);
        chk("hold_fp_b", fp_b, FP_THREE);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("hold_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_rsp0_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rsp0_id", 32'(rsp_id), 32'd0);
        chk("hold_rsp0_q", rsp_q, FP_TWO);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rsp1_id", 32'(rsp_id), 32'd1);
        chk("hold_rsp1_q", rsp_q, 32'hC0000000);
        @(posedge clk);
        #1;

        // Reset mid-flight discards both outstanding ops
        do_reset();
        set_op(0, FP_FIVE, FP_THREE);
        set_op(1, FP_FIVE, FP_ONE);
        set_op(2, FP_ONE, FP_ONE);
        req_valid = 4'b0001;
        @(posedge clk);
        #1 req_valid = 4'b0010;
        @(posedge clk);
        #1 req_valid = 4'b0100;
        areset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_fp_en", 32'(fp_en), 32'd0);
        @(posedge clk);
        #1 areset = 1'b0;
        req_valid = '0;
        for (int c = 0; c < LATENCY; c++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid_rst_inflight", 32'(inflight), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 4'b0011;
        @(negedge clk);
        chk("mid_rst_ptr", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (LATENCY + 1) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_sub_arbiter.md
Name: fp_sub_arbiter

Overview:
- Shares one pipelined single-precision subtractor (fp_sub: operands a, b; result q = a - b; fixed LATENCY) between NREQ requesters.
- Round-robin arbitration accepts at most one operation per cycle from a per-requester valid/ready port and drives it into the subtractor.
- A tag pipeline follows each operation, so the result returns with the owning requester's ID.
- Sits between the compute stages and the fp_sub instance. The fp_sub instance lives outside this block and connects through the fp_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 3, fp_sub cycles from operand sample to valid q (1..8).
- IDW, 2, requester ID width = clog2(NREQ).

Ports:
- clk  in  1  system clock.
- areset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_valid  in  NREQ  requester i has an operation pending.
- req_ready  out  NREQ  one-hot grant; operation i is accepted on an edge where req_valid[i] and req_ready[i] are both high.
- req_a  in  32*NREQ  minuend, IEEE-754 single; slice i belongs to requester i.
- req_b  in  32*NREQ  subtrahend, same slicing.
- rsp_valid  out  1  result valid this cycle.
- rsp_id  out  IDW  requester that owns the result.
- rsp_q  out  32  a - b result (fp_q passed through).
- fp_a  out  32  to fp_sub a.
- fp_b  out  32  to fp_sub b.
- fp_en  out  1  to fp_sub en.
- fp_areset  out  1  to fp_sub areset.
- fp_q  in  32  from fp_sub q.
- inflight  out  clog2(LATENCY+1)  operations issued but not yet returned.
- idle  out  1  high when inflight == 0 and no req_valid is high.

Behaviour:
- Reset: all registered state cleared.
  - tag pipeline valid bits = 0, tag IDs = 0, inflight = 0, round-robin pointer = NREQ-1 (requester 0 has top priority first).
  - While areset is high: req_ready = 0, rsp_valid = 0, rsp_id = 0, fp_en = 0, idle = 1.
  - fp_areset = areset (combinational).
  - Reset mid-operation discards every in-flight operation; no rsp_valid is produced for them.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i] high, searching upward from ptr+1 modulo NREQ.
  - req_ready is the one-hot grant, all-zero when no request is valid.
  - req_ready may depend on req_valid. Requesters must hold valid and operands stable until accepted.
- Issue:
  - fp_a and fp_b = req_a and req_b slices of the granted requester; 0 when no grant.
  - fp_en = 1 whenever areset is low, so the pipeline free-runs and never stalls.
  - On an accept edge, ptr <= granted index. Otherwise ptr holds.
- Tag pipeline:
  - LATENCY stages of {valid, id}. Stage 0 loads {accept, granted id} each edge; stage k loads stage k-1.
  - rsp_valid = last-stage valid; rsp_id = last-stage id; rsp_q = fp_q.
  - Result for an op accepted in cycle t is presented in cycle t+LATENCY, aligned with fp_q.
- Response has no backpressure: rsp_valid is a one-cycle pulse and the owner must capture it.
- Throughput is 1 op/cycle; back-to-back issues return back-to-back in issue order.
- inflight:
  - +1 on accept, -1 when rsp_valid is high.
  - Simultaneous accept and retire leaves it unchanged.
  - Never exceeds LATENCY.
- Fairness: a continuously asserting requester waits at most NREQ-1 cycles for a grant.
- Result flags and NaN/Inf handling are the subtractor's concern; this block passes q through bit-exact.

Decomposition:
- Shared package fp_pkg:
  - FP_W = 32.
  - Constants FP_ZERO 32'h00000000, FP_ONE 32'h3F800000, FP_TWO 32'h40000000, FP_THREE 32'h40400000, FP_FIVE 32'h40A00000.
  - Function clog2.
- One natural sub-module, rr_arbiter (NREQ): inputs req, ptr; output one-hot grant and encoded index. It can be reused by later shared FP resources (adder, multiplier).
- Tag pipeline, inflight counter and port muxing stay in fp_sub_arbiter.
- The bench instantiates a behavioural fp_sub model with configurable LATENCY.

Test Plan:
- Single op, LATENCY=3: areset held 2 cycles, then req 1 presents a=40A00000 (5.0), b=40400000 (3.0) in cycle 5.
  - req_ready[1]=1 in cycle 5.
  - rsp_valid=1, rsp_id=1, rsp_q=40000000 in cycle 8 only.
  - inflight returns to 0; idle=1.
- All 4 requesters valid continuously from the cycle after reset (req i: a=40400000, b=3F800000):
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Responses stream 3 cycles later with rsp_id 0,1,2,3,0, every rsp_q=40000000.
  - inflight=3 in steady state.
- Sign result: req 2 a=3F800000, b=40400000 -> rsp_id=2, rsp_q=C0000000.
  - Zero case: req 0 a=b=00000000 -> rsp_q=00000000.
- Fairness: req 0 always valid, req 3 asserts in cycle 10 -> req 3 is granted by cycle 13 at latest.
  - req 0 never granted twice in a row while req 3 is waiting.
- Reset mid-flight: issue ops in cycles 5 and 6, assert areset in cycle 7 for one cycle.
  - No rsp_valid in cycles 8 or 9.
  - inflight=0, ptr restored so requester 0 wins the first post-reset contention.
- Hold rule: req 1 valid while req 0 is being granted -> req_ready[1] stays 0 and req 1 keeps its operands stable.
  - req 1 is accepted the next cycle and its result carries rsp_id=1.
